// File: rtl/sram_arbiter_if.sv
// Requester and SRAM bus bundle for sram_arbiter: fetch port, data port, SRAM side.
interface sram_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic [DATA_W-1:0] dm_rdata;

  logic              sram_en;
  logic              sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    output dm_gnt, dm_rvalid, dm_rdata,
    output sram_en, sram_we, sram_addr, sram_wdata,
    input  sram_rdata
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output dm_req, dm_we, dm_addr, dm_wdata,
    input  dm_gnt, dm_rvalid, dm_rdata,
    input  sram_en, sram_we, sram_addr, sram_wdata,
    output sram_rdata
  );
endinterface

// File: rtl/sram_arbiter.sv
// Two-port (fetch/data) single-SRAM arbiter, 1-cycle response, conflict counter.
// Define ARB_ROUND_ROBIN_EN for alternating grants on conflict; default is fixed dm priority.
module sram_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic           clk,
  input  logic           reset,
  sram_arbiter_if.slave  bus,
  output logic [15:0]    conflict_cnt
);

  typedef enum logic {IDLE, RESP} resp_e;

  resp_e if_st, dm_st;
  logic  dm_wr_q;
  logic  conflict, if_win, dm_win;

  assign conflict = bus.if_req & bus.dm_req;

`ifdef ARB_ROUND_ROBIN_EN
  // 1: fetch wins the next conflict; moves only on conflict cycles
  logic rr_if;

  always_comb begin
    dm_win = bus.dm_req & ~(conflict & rr_if);
    if_win = bus.if_req & ~dm_win;
  end

  always_ff @(posedge clk) begin
    if (reset)         rr_if <= 1'b0;
    else if (conflict) rr_if <= dm_win;
  end
`else
  always_comb begin
    dm_win = bus.dm_req;
    if_win = bus.if_req & ~bus.dm_req;
  end
`endif

  assign bus.if_gnt = if_win & ~reset;
  assign bus.dm_gnt = dm_win & ~reset;

  always_comb begin
    bus.sram_en    = 1'b0;
    bus.sram_we    = 1'b0;
    bus.sram_addr  = {ADDR_W{1'b0}};
    bus.sram_wdata = {DATA_W{1'b0}};
    if (bus.dm_gnt) begin
      bus.sram_en    = 1'b1;
      bus.sram_we    = bus.dm_we;
      bus.sram_addr  = bus.dm_addr;
      bus.sram_wdata = bus.dm_wdata;
    end else if (bus.if_gnt) begin
      bus.sram_en    = 1'b1;
      bus.sram_addr  = bus.if_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      if_st   <= IDLE;
      dm_st   <= IDLE;
      dm_wr_q <= 1'b0;
    end else begin
      if_st <= bus.if_gnt ? RESP : IDLE;
      dm_st <= bus.dm_gnt ? RESP : IDLE;
      if (bus.dm_gnt) dm_wr_q <= bus.dm_we;
    end
  end

  // Masking with reset drops a response whose grant landed just before reset
  assign bus.if_rvalid = (if_st == RESP) & ~reset;
  assign bus.dm_rvalid = (dm_st == RESP) & ~reset;
  assign bus.if_rdata  = bus.if_rvalid ? bus.sram_rdata : {DATA_W{1'b0}};
  assign bus.dm_rdata  = (bus.dm_rvalid & ~dm_wr_q) ? bus.sram_rdata : {DATA_W{1'b0}};

  always_ff @(posedge clk) begin
    if (reset)                                  conflict_cnt <= 16'h0;
    else if (conflict && conflict_cnt != 16'hFFFF) conflict_cnt <= conflict_cnt + 16'h1;
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed self-checking bench for sram_arbiter.
module tb_sram_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] conflict_cnt;
  int checks = 0;
  int errors = 0;

  sram_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus();

  sram_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .conflict_cnt (conflict_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.if_req = 0; bus.if_addr = 0;
    bus.dm_req = 0; bus.dm_we = 0; bus.dm_addr = 0; bus.dm_wdata = 0;
    bus.sram_rdata = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    bus.if_req = 1; bus.dm_req = 1; bus.if_addr = 32'h40; bus.dm_addr = 32'h80;
    step(); step();
    checks++; if (bus.if_gnt !== 1'b0 || bus.dm_gnt !== 1'b0) begin errors++;
      $display("FAIL reset_gnt: if_gnt=%b dm_gnt=%b, want 0 0", bus.if_gnt, bus.dm_gnt); end
    checks++; if (bus.sram_en !== 1'b0 || bus.sram_addr !== 32'h0) begin errors++;
      $display("FAIL reset_sram: en=%b addr=%h, want 0 0", bus.sram_en, bus.sram_addr); end
    checks++; if (conflict_cnt !== 16'h0) begin errors++;
      $display("FAIL reset_cnt: got %h want 0000", conflict_cnt); end
    checks++; if (bus.if_rvalid !== 1'b0 || bus.dm_rvalid !== 1'b0 || bus.if_rdata !== 32'h0) begin errors++;
      $display("FAIL reset_rvalid: if=%b dm=%b rdata=%h, want 0 0 0", bus.if_rvalid, bus.dm_rvalid, bus.if_rdata); end
    idle_inputs();
  endtask

  task automatic test_fetch_read();
    reset = 0;
    bus.if_req = 1; bus.if_addr = 32'h1C000000;
    #1;
    checks++; if (bus.if_gnt !== 1'b1 || bus.sram_en !== 1'b1 || bus.sram_we !== 1'b0) begin errors++;
      $display("FAIL fetch_gnt: gnt=%b en=%b we=%b, want 1 1 0", bus.if_gnt, bus.sram_en, bus.sram_we); end
    checks++; if (bus.sram_addr !== 32'h1C000000) begin errors++;
      $display("FAIL fetch_addr: got %h want 1c000000", bus.sram_addr); end
    step();
    bus.if_req = 0; bus.sram_rdata = 32'h02800C0C;
    #1;
    checks++; if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== 32'h02800C0C) begin errors++;
      $display("FAIL fetch_resp: rvalid=%b rdata=%h, want 1 02800c0c", bus.if_rvalid, bus.if_rdata); end
    checks++; if (bus.sram_en !== 1'b0 || bus.dm_rvalid !== 1'b0) begin errors++;
      $display("FAIL fetch_idle_sram: en=%b dm_rvalid=%b, want 0 0", bus.sram_en, bus.dm_rvalid); end
    step();
    checks++; if (bus.if_rvalid !== 1'b0 || bus.if_rdata !== 32'h0) begin errors++;
      $display("FAIL fetch_resp_end: rvalid=%b rdata=%h, want 0 0", bus.if_rvalid, bus.if_rdata); end
  endtask

  task automatic test_data_write();
    bus.dm_req = 1; bus.dm_we = 1; bus.dm_addr = 32'h100; bus.dm_wdata = 32'hDEADBEEF;
    #1;
    checks++; if (bus.dm_gnt !== 1'b1 || bus.sram_we !== 1'b1 || bus.sram_wdata !== 32'hDEADBEEF || bus.sram_addr !== 32'h100) begin errors++;
      $display("FAIL write_gnt: gnt=%b we=%b wdata=%h addr=%h, want 1 1 deadbeef 100",
               bus.dm_gnt, bus.sram_we, bus.sram_wdata, bus.sram_addr); end
    step();
    bus.dm_req = 0; bus.dm_we = 0; bus.sram_rdata = 32'h12345678;
    #1;
    checks++; if (bus.dm_rvalid !== 1'b1 || bus.dm_rdata !== 32'h0) begin errors++;
      $display("FAIL write_ack: rvalid=%b rdata=%h, want 1 0", bus.dm_rvalid, bus.dm_rdata); end
    step();
    checks++; if (bus.dm_rvalid !== 1'b0) begin errors++;
      $display("FAIL write_ack_end: rvalid=%b want 0", bus.dm_rvalid); end
  endtask

  task automatic test_conflict();
    logic [3:0] want_dm;
`ifdef ARB_ROUND_ROBIN_EN
    want_dm = 4'b0101;  // bit i = dm wins cycle i
`else
    want_dm = 4'b1111;
`endif
    bus.if_req = 1; bus.if_addr = 32'h20;
    bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h300;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (bus.dm_gnt !== want_dm[i] || bus.if_gnt !== ~want_dm[i]) begin errors++;
        $display("FAIL conflict_gnt[%0d]: dm=%b if=%b, want %b %b", i, bus.dm_gnt, bus.if_gnt, want_dm[i], ~want_dm[i]); end
      step();
    end
    bus.if_req = 0; bus.dm_req = 0; bus.sram_rdata = 32'hCAFEF00D;
    #1;
    checks++; if (conflict_cnt !== 16'd4) begin errors++;
      $display("FAIL conflict_cnt: got %0d want 4", conflict_cnt); end
    checks++; if (bus.dm_rvalid !== want_dm[3] || bus.if_rvalid !== ~want_dm[3]) begin errors++;
      $display("FAIL conflict_resp: dm=%b if=%b", bus.dm_rvalid, bus.if_rvalid); end
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] data [3];
    data[0] = 32'hA0A0A0A0; data[1] = 32'hB1B1B1B1; data[2] = 32'hC2C2C2C2;
    bus.if_req = 1;
    for (int i = 0; i < 4; i++) begin
      if (i < 3) bus.if_addr = 32'(i * 4); else bus.if_req = 0;
      if (i > 0) bus.sram_rdata = data[i-1];
      #1;
      if (i < 3) begin
        checks++; if (bus.if_gnt !== 1'b1 || bus.sram_addr !== 32'(i * 4)) begin errors++;
          $display("FAIL b2b_gnt[%0d]: gnt=%b addr=%h", i, bus.if_gnt, bus.sram_addr); end
      end
      if (i > 0) begin
        checks++; if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== data[i-1]) begin errors++;
          $display("FAIL b2b_resp[%0d]: rvalid=%b rdata=%h want 1 %h", i, bus.if_rvalid, bus.if_rdata, data[i-1]); end
      end
      step();
    end
    checks++; if (bus.if_rvalid !== 1'b0) begin errors++;
      $display("FAIL b2b_end: rvalid=%b want 0", bus.if_rvalid); end
  endtask

  task automatic test_reset_mid_grant();
    bus.if_req = 1; bus.if_addr = 32'h44;
    #1;
    checks++; if (bus.if_gnt !== 1'b1) begin errors++;
      $display("FAIL rst_mid_gnt: gnt=%b want 1", bus.if_gnt); end
    step();
    reset = 1; bus.sram_rdata = 32'h55AA55AA;
    #1;
    checks++; if (bus.if_rvalid !== 1'b0 || bus.if_rdata !== 32'h0 || bus.if_gnt !== 1'b0 || bus.sram_en !== 1'b0) begin errors++;
      $display("FAIL rst_mid_during: rvalid=%b rdata=%h gnt=%b en=%b, want all 0",
               bus.if_rvalid, bus.if_rdata, bus.if_gnt, bus.sram_en); end
    step();
    reset = 0; bus.if_req = 0;
    #1;
    checks++; if (bus.if_rvalid !== 1'b0 || conflict_cnt !== 16'h0) begin errors++;
      $display("FAIL rst_mid_after: rvalid=%b cnt=%h, want 0 0", bus.if_rvalid, conflict_cnt); end
    step();
  endtask

  task automatic test_saturate();
    bus.if_req = 1; bus.dm_req = 1;
    for (int i = 0; i < 65534; i++) step();
    checks++; if (conflict_cnt !== 16'hFFFE) begin errors++;
      $display("FAIL sat_preload: got %h want fffe", conflict_cnt); end
    for (int i = 0; i < 3; i++) step();
    checks++; if (conflict_cnt !== 16'hFFFF) begin errors++;
      $display("FAIL sat_hold: got %h want ffff", conflict_cnt); end
    idle_inputs();
    step();
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    #1;
    test_reset();
    test_fetch_read();
    test_data_write();
    test_conflict();
    test_back_to_back();
    test_reset_mid_grant();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
